// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and 512-bit block output of the SHA-256 message padder.
// The padder uses the slave view; the message source / compression core use the master view.
interface sha256_msg_padder_if;
  logic         msg_valid;
  logic         msg_ready;
  logic [7:0]   msg_data;
  logic         msg_last;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_data;
  logic         block_last;
  logic         msg_error;

  modport master (
    output msg_valid, msg_data, msg_last, block_ready,
    input  msg_ready, block_valid, block_data, block_last, msg_error
  );

  modport slave (
    input  msg_valid, msg_data, msg_last, block_ready,
    output msg_ready, block_valid, block_data, block_last, msg_error
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 padder: message bytes in, 512-bit padded blocks out (0x80, zero fill, 64-bit bit length).
// Optional byte-count overflow detection is enabled by defining SHA256_PAD_OVERFLOW_CHECK_EN.
module sha256_msg_padder #(
  parameter int MAX_MSG_BYTES = 119,
  parameter int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
  input logic                clock,
  input logic                reset,
  sha256_msg_padder_if.slave bus
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [63:0][7:0] blk;          // blk[63] is byte 0 of the block
  logic [5:0]       byte_ptr;
  logic [LEN_W-1:0] byte_cnt;
  logic             blk_last;
  logic             pad_pending;
  logic             len_pending;
  logic             armed;

  logic             msg_ready_int;
  logic             block_valid_int;
  logic             byte_xfer;
  logic             block_xfer;
  logic             drop_byte;
  logic [63:0]      bit_len;

  assign byte_xfer  = bus.msg_valid && msg_ready_int;
  assign block_xfer = block_valid_int && bus.block_ready;
  assign bit_len    = {{(61 - LEN_W){1'b0}}, byte_cnt, 3'b000};

`ifdef SHA256_PAD_OVERFLOW_CHECK_EN
  logic err;
  assign drop_byte = (byte_cnt == LEN_W'(MAX_MSG_BYTES));
  assign bus.msg_error = err;
`else
  assign drop_byte = 1'b0;
  assign bus.msg_error = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a dropped byte never fills a slot, so it cannot trigger EMIT
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (byte_xfer) begin
          if (byte_ptr == 6'd63 && !drop_byte) begin
            state_nxt = EMIT;
          end else if (bus.msg_last) begin
            state_nxt = PAD;
          end
        end
      end
      PAD:  state_nxt = EMIT;
      LEN:  state_nxt = EMIT;
      EMIT: begin
        if (block_xfer) begin
          if (blk_last) begin
            state_nxt = FILL;
          end else if (pad_pending) begin
            state_nxt = PAD;
          end else if (len_pending) begin
            state_nxt = LEN;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Outputs; armed keeps msg_ready low for the first cycle after reset release
  always_comb begin
    msg_ready_int   = 1'b0;
    block_valid_int = 1'b0;
    case (state)
      FILL:    msg_ready_int   = armed;
      EMIT:    block_valid_int = 1'b1;
      default: ;
    endcase
  end

  assign bus.msg_ready   = msg_ready_int;
  assign bus.block_valid = block_valid_int;
  assign bus.block_data  = blk;
  assign bus.block_last  = blk_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blk         <= '0;
      byte_ptr    <= '0;
      byte_cnt    <= '0;
      blk_last    <= 1'b0;
      pad_pending <= 1'b0;
      len_pending <= 1'b0;
      armed       <= 1'b0;
`ifdef SHA256_PAD_OVERFLOW_CHECK_EN
      err         <= 1'b0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        FILL: begin
          if (byte_xfer && !drop_byte) begin
            blk[~byte_ptr] <= bus.msg_data;
            byte_ptr       <= byte_ptr + 6'd1;
            byte_cnt       <= byte_cnt + LEN_W'(1);
            if (bus.msg_last && byte_ptr == 6'd63) begin
              pad_pending <= 1'b1;
            end
          end
        end
        PAD: begin
          blk[~byte_ptr] <= 8'h80;
          if (byte_ptr <= 6'd55) begin
            blk[7:0] <= bit_len;
            blk_last <= 1'b1;
          end else begin
            len_pending <= 1'b1;
          end
        end
        LEN: begin
          blk[7:0] <= bit_len;
          blk_last <= 1'b1;
        end
        EMIT: begin
          if (block_xfer) begin
            blk         <= '0;
            byte_ptr    <= '0;
            blk_last    <= 1'b0;
            pad_pending <= 1'b0;
            len_pending <= 1'b0;
            if (blk_last) begin
              byte_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
`ifdef SHA256_PAD_OVERFLOW_CHECK_EN
      if (state == FILL && byte_xfer && drop_byte) begin
        err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed padding cases plus randomized messages against a byte-list padding model.
module tb_sha256_msg_padder;
  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   cyc;

  sha256_msg_padder_if bus ();

  sha256_msg_padder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0]   msg [256];
  logic [511:0] exp_blk [$];
  logic         exp_last [$];
  int           hs_cyc [$];

  // Padded stream = msg ++ 0x80 ++ zeros until 56 mod 64 ++ 64-bit big-endian bit count
  task automatic build_expected(input int n);
    logic [7:0]   pb [$];
    logic [63:0]  bits;
    logic [511:0] b;
    int           nblk;
    pb = {};
    for (int i = 0; i < n; i++) pb.push_back(msg[i]);
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    bits = 64'(n) * 64'd8;
    for (int i = 7; i >= 0; i--) pb.push_back(bits[8*i +: 8]);
    nblk = pb.size() / 64;
    exp_blk  = {};
    exp_last = {};
    for (int j = 0; j < nblk; j++) begin
      b = '0;
      for (int k = 0; k < 64; k++) b[511 - 8*k -: 8] = pb[64*j + k];
      exp_blk.push_back(b);
      exp_last.push_back(j == nblk - 1);
    end
  endtask

  task automatic send_msg(input int start, input int n, input bit do_last, input int gap_pct);
    int budget;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.msg_valid = 1'b0;
        @(posedge clock); #1;
      end
      bus.msg_valid = 1'b1;
      bus.msg_data  = msg[start + i];
      bus.msg_last  = do_last && (i == n - 1);
      budget = 0;
      forever begin
        @(negedge clock);
        if (bus.msg_ready) break;
        budget++;
        if (budget > 1000) begin
          total++; bad++;
          $display("FAIL send_timeout byte=%0d msg_ready=%b required=1", start + i, bus.msg_ready);
          bus.msg_valid = 1'b0;
          bus.msg_last  = 1'b0;
          return;
        end
      end
      @(posedge clock); #1;
    end
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
  endtask

  task automatic collect(input int rdy_pct);
    int           budget;
    logic         hold_vld;
    logic [511:0] held;
    hold_vld = 1'b0;
    held     = '0;
    hs_cyc   = {};
    while (exp_blk.size() > 0) begin
      budget = 0;
      forever begin
        @(posedge clock); #1;
        bus.block_ready = ($urandom_range(99) < rdy_pct);
        @(negedge clock);
        if (hold_vld) begin
          total++;
          if (bus.block_valid !== 1'b1 || bus.block_data !== held) begin
            bad++;
            $display("FAIL hold_stable block_valid=%b data=%h required=%h", bus.block_valid, bus.block_data, held);
          end
        end
        if (bus.block_valid && bus.block_ready) break;
        hold_vld = bus.block_valid;
        held     = bus.block_data;
        budget++;
        if (budget > 2000) begin
          total++; bad++;
          $display("FAIL block_timeout remaining=%0d required=0", exp_blk.size());
          exp_blk = {}; exp_last = {};
          bus.block_ready = 1'b0;
          return;
        end
      end
      hold_vld = 1'b0;
      hs_cyc.push_back(cyc);
      total++;
      if (bus.block_data !== exp_blk[0] || bus.block_last !== exp_last[0]) begin
        bad++;
        $display("FAIL block_content last=%b data=%h required last=%b data=%h",
                 bus.block_last, bus.block_data, exp_last[0], exp_blk[0]);
      end
      void'(exp_blk.pop_front());
      void'(exp_last.pop_front());
    end
    @(posedge clock); #1;
    bus.block_ready = 1'b0;
  endtask

  task automatic run_msg(input int n, input int gap_pct, input int rdy_pct);
    build_expected(n);
    fork
      send_msg(0, n, 1'b1, gap_pct);
      collect(rdy_pct);
    join
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (bus.msg_ready !== 1'b0 || bus.block_valid !== 1'b0 || bus.block_last !== 1'b0 ||
        bus.block_data !== '0 || bus.msg_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs rdy=%b vld=%b last=%b err=%b required all 0",
               bus.msg_ready, bus.block_valid, bus.block_last, bus.msg_error);
    end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1;
    total++;
    if (bus.msg_ready !== 1'b0) begin
      bad++; $display("FAIL ready_after_release got=%b required=0", bus.msg_ready);
    end
    @(posedge clock); #1;
    total++;
    if (bus.msg_ready !== 1'b1) begin
      bad++; $display("FAIL ready_next_cycle got=%b required=1", bus.msg_ready);
    end
  endtask

  task automatic test_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    build_expected(3);
    bus.block_ready = 1'b0;
    send_msg(0, 3, 1'b1, 0);
    total++;
    if (bus.block_valid !== 1'b0) begin
      bad++; $display("FAIL abc_latency_early block_valid=%b required=0", bus.block_valid);
    end
    @(posedge clock); #1;
    total++;
    if (bus.block_valid !== 1'b1 || bus.block_last !== 1'b1 || bus.block_data !== exp_blk[0]) begin
      bad++;
      $display("FAIL abc_block vld=%b last=%b data=%h required vld=1 last=1 data=%h",
               bus.block_valid, bus.block_last, bus.block_data, exp_blk[0]);
    end
    total++;
    if (bus.block_data[511:480] !== 32'h61626380 || bus.block_data[63:0] !== 64'h18) begin
      bad++; $display("FAIL abc_fields head=%h len=%h required 61626380/18",
                      bus.block_data[511:480], bus.block_data[63:0]);
    end
    bus.block_ready = 1'b1;
    @(posedge clock); #1;
    bus.block_ready = 1'b0;
    total++;
    if (bus.block_valid !== 1'b0 || bus.msg_ready !== 1'b1) begin
      bad++; $display("FAIL abc_after_hs vld=%b rdy=%b required vld=0 rdy=1", bus.block_valid, bus.msg_ready);
    end
    exp_blk = {}; exp_last = {};
  endtask

  task automatic test_boundaries();
    int lens [3] = '{55, 56, 64};
    int nblk [3] = '{1, 2, 2};
    foreach (lens[t]) begin
      for (int i = 0; i < lens[t]; i++) msg[i] = (t == 0) ? 8'h00 : 8'($urandom);
      run_msg(lens[t], 0, 100);
      total++;
      if (hs_cyc.size() !== nblk[t]) begin
        bad++; $display("FAIL boundary_nblk len=%0d got=%0d required=%0d", lens[t], hs_cyc.size(), nblk[t]);
      end else if (nblk[t] == 2 && hs_cyc[1] - hs_cyc[0] !== 2) begin
        total++; bad++;
        $display("FAIL tail_block_latency len=%0d got=%0d required=2", lens[t], hs_cyc[1] - hs_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] held;
    logic         held_last;
    int           budget;
    for (int i = 0; i < 10; i++) msg[i] = 8'($urandom);
    build_expected(10);
    bus.block_ready = 1'b0;
    send_msg(0, 10, 1'b1, 0);
    budget = 0;
    while (bus.block_valid !== 1'b1 && budget < 20) begin
      @(posedge clock); #1; budget++;
    end
    held      = bus.block_data;
    held_last = bus.block_last;
    total++;
    if (held !== exp_blk[0] || held_last !== 1'b1) begin
      bad++; $display("FAIL bp_block last=%b data=%h required last=1 data=%h", held_last, held, exp_blk[0]);
    end
    bus.msg_valid = 1'b1;
    bus.msg_data  = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      total++;
      if (bus.block_valid !== 1'b1 || bus.block_data !== held || bus.block_last !== held_last ||
          bus.msg_ready !== 1'b0) begin
        bad++; $display("FAIL bp_stall cycle=%0d vld=%b last=%b rdy=%b required vld=1 last=%b rdy=0",
                        c, bus.block_valid, bus.block_last, bus.msg_ready, held_last);
      end
    end
    bus.msg_valid   = 1'b0;
    bus.block_ready = 1'b1;
    @(posedge clock); #1;
    bus.block_ready = 1'b0;
    total++;
    if (bus.block_valid !== 1'b0 || bus.block_data !== '0) begin
      bad++; $display("FAIL bp_release vld=%b required=0", bus.block_valid);
    end
    exp_blk = {}; exp_last = {};
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) msg[i] = 8'($urandom);
    send_msg(0, 20, 1'b0, 0);
    reset = 1'b1;
    #1;
    total++;
    if (bus.msg_ready !== 1'b0 || bus.block_valid !== 1'b0 || bus.block_data !== '0 || bus.block_last !== 1'b0) begin
      bad++; $display("FAIL reset_mid_clear rdy=%b vld=%b last=%b required all 0",
                      bus.msg_ready, bus.block_valid, bus.block_last);
    end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 0, 100);
    total++;
    if (hs_cyc.size() !== 1) begin
      bad++; $display("FAIL reset_mid_abc blocks=%0d required=1", hs_cyc.size());
    end
  endtask

  task automatic test_random();
    int n;
    for (int m = 0; m < 10; m++) begin
      n = (m == 0) ? 1 : (m == 1) ? 63 : (m == 2) ? 119 : $urandom_range(1, 119);
      for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
      run_msg(n, $urandom_range(0, 40), $urandom_range(30, 100));
    end
    total++;
    if (bus.msg_error !== 1'b0) begin
      bad++; $display("FAIL random_no_error msg_error=%b required=0", bus.msg_error);
    end
  endtask

`ifdef SHA256_PAD_OVERFLOW_CHECK_EN
  task automatic test_overflow();
    for (int i = 0; i < 121; i++) msg[i] = 8'($urandom);
    build_expected(119);
    fork
      begin
        send_msg(0, 119, 1'b0, 0);
        total++;
        if (bus.msg_error !== 1'b0) begin
          bad++; $display("FAIL ovf_early msg_error=%b required=0", bus.msg_error);
        end
        send_msg(119, 1, 1'b0, 0);
        total++;
        if (bus.msg_error !== 1'b1) begin
          bad++; $display("FAIL ovf_flag msg_error=%b required=1", bus.msg_error);
        end
        send_msg(120, 1, 1'b1, 0);
      end
      collect(100);
    join
    total++;
    if (bus.msg_error !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky msg_error=%b required=1", bus.msg_error);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b1;
    bus.msg_valid   = 1'b0;
    bus.msg_data    = 8'h00;
    bus.msg_last    = 1'b0;
    bus.block_ready = 1'b0;
    test_reset();
    test_abc();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef SHA256_PAD_OVERFLOW_CHECK_EN
    test_overflow();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
